// File: rtl/spu_logic_arb.sv
// spu_logic_arb: round-robin arbiter sharing one configurable bitwise-logic
// unit between NUM_REQ requesters. Results are tagged with the issuing
// requester and return in issue order through a credit-protected output FIFO.

// Configurable bitwise-logic unit with LATENCY register stages.
module spu_logic_cfg #(
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cke,
    input  logic [3:0]           cfg,
    input  logic [DATA_BITS-1:0] data0,
    input  logic [DATA_BITS-1:0] data1,
    output logic [DATA_BITS-1:0] result
);

    logic [DATA_BITS-1:0] op_a;
    logic [DATA_BITS-1:0] op_b;
    logic [DATA_BITS-1:0] func;

    // Optional operand inversion, then AND/OR/XOR/pass-a selected by cfg[1:0].
    always_comb begin
        op_a = cfg[3] ? ~data0 : data0;
        op_b = cfg[2] ? ~data1 : data1;
        func = op_a;
        case (cfg[1:0])
            2'd0:    func = op_a & op_b;
            2'd1:    func = op_a | op_b;
            2'd2:    func = op_a ^ op_b;
            default: func = op_a;
        endcase
    end

    generate
        if (LATENCY == 0) begin : g_comb
            assign result = func;
        end else begin : g_pipe
            logic [LATENCY-1:0][DATA_BITS-1:0] stage;
            logic [LATENCY:0][DATA_BITS-1:0]   chain;

            // chain[0] is the fresh result; chain[LATENCY] is the oldest stage.
            assign chain  = {stage, func};
            assign result = chain[LATENCY];

            // Result pipeline, frozen while cke is low.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage <= '0;
                end else if (cke) begin
                    stage <= chain[LATENCY-1:0];
                end
            end
        end
    endgenerate

endmodule

module spu_logic_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ID_BITS    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cke,
    input  logic [NUM_REQ-1:0]                s_valid,
    output logic [NUM_REQ-1:0]                s_ready,
    input  logic [NUM_REQ-1:0][3:0]           s_cfg,
    input  logic [NUM_REQ-1:0][DATA_BITS-1:0] s_data0,
    input  logic [NUM_REQ-1:0][DATA_BITS-1:0] s_data1,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [ID_BITS-1:0]                m_id,
    output logic [DATA_BITS-1:0]              m_data
);

    localparam int unsigned CNT_BITS = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned TW       = ID_BITS + 1;

    logic [ID_BITS-1:0]   rr_ptr;
    logic [ID_BITS-1:0]   grant_idx;
    logic                 grant_found;
    logic                 can_issue;
    logic                 issue;
    logic                 pop;
    logic                 fifo_wr;
    logic [CNT_BITS-1:0]  credit;
    logic [CNT_BITS-1:0]  fifo_cnt;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] data_mem [FIFO_DEPTH];
    logic [ID_BITS-1:0]   id_mem   [FIFO_DEPTH];

    logic [3:0]           u_cfg;
    logic [DATA_BITS-1:0] u_d0;
    logic [DATA_BITS-1:0] u_d1;
    logic [DATA_BITS-1:0] u_res;

    logic [TW-1:0]        tag_in;
    logic [TW-1:0]        tag_out;
    logic                 tag_out_v;
    logic [ID_BITS-1:0]   tag_out_id;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Circular search for the first valid requester after the rr pointer.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && s_valid[ID_BITS'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_BITS'(idx);
            end
        end
    end

    // Holding reset low also blocks acceptance: anything taken then would be lost.
    assign can_issue = cke & reset & (credit < CNT_BITS'(FIFO_DEPTH));
    assign issue     = can_issue & grant_found;
    assign pop       = m_valid & m_ready;
    assign fifo_wr   = tag_out_v & cke;

    // One-hot accept towards the granted requester.
    always_comb begin
        s_ready = '0;
        if (issue) begin
            s_ready[grant_idx] = 1'b1;
        end
    end

    // Granted operands into the shared unit; idle input is zero.
    always_comb begin
        u_cfg = '0;
        u_d0  = '0;
        u_d1  = '0;
        if (issue) begin
            u_cfg = s_cfg[grant_idx];
            u_d0  = s_data0[grant_idx];
            u_d1  = s_data1[grant_idx];
        end
    end

    spu_logic_cfg #(
        .LATENCY   (LATENCY),
        .DATA_BITS (DATA_BITS)
    ) u_logic (
        .clk    (clk),
        .rst    (~reset),
        .cke    (cke),
        .cfg    (u_cfg),
        .data0  (u_d0),
        .data1  (u_d1),
        .result (u_res)
    );

    assign tag_in = {issue, grant_idx};

    generate
        if (LATENCY == 0) begin : g_tag_comb
            assign tag_out = tag_in;
        end else begin : g_tag_pipe
            logic [LATENCY-1:0][TW-1:0] tag_q;
            logic [LATENCY:0][TW-1:0]   tag_chain;

            assign tag_chain = {tag_q, tag_in};
            assign tag_out   = tag_chain[LATENCY];

            // {valid,id} tags travel in lockstep with the logic unit.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    tag_q <= '0;
                end else if (cke) begin
                    tag_q <= tag_chain[LATENCY-1:0];
                end
            end
        end
    endgenerate

    assign tag_out_v  = tag_out[TW-1];
    assign tag_out_id = tag_out[ID_BITS-1:0];

    // Round-robin pointer follows the last granted requester.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= ID_BITS'(NUM_REQ - 1);
        end else if (issue) begin
            rr_ptr <= grant_idx;
        end
    end

    // Credits cover queued plus in-flight results so the FIFO cannot overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            credit <= '0;
        end else if (issue && !pop) begin
            credit <= credit + CNT_BITS'(1);
        end else if (!issue && pop) begin
            credit <= credit - CNT_BITS'(1);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (fifo_wr && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_BITS'(1);
            end else if (!fifo_wr && pop) begin
                fifo_cnt <= fifo_cnt - CNT_BITS'(1);
            end
        end
    end

    // FIFO storage; contents are masked on the outputs while empty.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            data_mem[wr_ptr] <= u_res;
            id_mem[wr_ptr]   <= tag_out_id;
        end
    end

    assign m_valid = (fifo_cnt != '0);
    assign m_id    = m_valid ? id_mem[rd_ptr]   : '0;
    assign m_data  = m_valid ? data_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_spu_logic_arb.sv
// Directed bench for spu_logic_arb (NUM_REQ=4, LATENCY=1, DATA_BITS=8, FIFO_DEPTH=4).
module tb_spu_logic_arb;

    logic             clk = 1'b0;
    logic             reset;
    logic             cke;
    logic [3:0]       s_valid;
    logic [3:0]       s_ready;
    logic [3:0][3:0]  s_cfg;
    logic [3:0][7:0]  s_data0;
    logic [3:0][7:0]  s_data1;
    logic             m_valid;
    logic             m_ready;
    logic [1:0]       m_id;
    logic [7:0]       m_data;

    int total = 0;
    int bad   = 0;

    logic [3:0] op_tab  [9] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'hA, 4'hC, 4'hD, 4'hF};
    logic [7:0] res_tab [9] = '{8'hFC, 8'hCC, 8'hF0, 8'hF3, 8'h33, 8'h33, 8'h03, 8'hCF, 8'h0F};

    spu_logic_arb #(
        .NUM_REQ    (4),
        .LATENCY    (1),
        .DATA_BITS  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cke     (cke),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_cfg   (s_cfg),
        .s_data0 (s_data0),
        .s_data1 (s_data1),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_id    (m_id),
        .m_data  (m_data)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0; cke = 1'b1; m_ready = 1'b1; s_valid = '0;
        s_cfg = '0; s_data0 = '0; s_data1 = '0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({m_valid, m_id, m_data} !== 11'h0) begin
            bad++; $display("FAIL reset_out got=%h want=000", {m_valid, m_id, m_data});
        end
        total++;
        if (s_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_ready got=%b want=0000", s_ready);
        end
        reset = 1'b1;
        @(negedge clk); #1;
        total++;
        if (m_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release_valid got=%b want=0", m_valid);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        s_valid = 4'b0100; s_cfg[2] = 4'h0; s_data0[2] = 8'hF0; s_data1[2] = 8'h3C;
        #1;
        total++;
        if (s_ready !== 4'b0100) begin
            bad++; $display("FAIL single_ready got=%b want=0100", s_ready);
        end
        @(negedge clk);
        s_valid = '0;
        #1;
        total++;
        if ({s_ready, m_valid} !== 5'b0) begin
            bad++; $display("FAIL single_idle got=%b want=00000", {s_ready, m_valid});
        end
        @(negedge clk); #1;
        total++;
        if ({m_valid, m_id, m_data} !== {1'b1, 2'd2, 8'h30}) begin
            bad++; $display("FAIL single_result got=%h want=%h", {m_valid, m_id, m_data}, {1'b1, 2'd2, 8'h30});
        end
        @(negedge clk); #1;
        total++;
        if (m_valid !== 1'b0) begin
            bad++; $display("FAIL single_once got=%b want=0", m_valid);
        end
    endtask

    task automatic test_op_sweep();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            s_valid = 4'b0001; s_cfg[0] = op_tab[i]; s_data0[0] = 8'hF0; s_data1[0] = 8'h3C;
            #1;
            total++;
            if (s_ready !== 4'b0001) begin
                bad++; $display("FAIL op_ready[%0d] got=%b want=0001", i, s_ready);
            end
            @(negedge clk);
            s_valid = '0;
            @(negedge clk); #1;
            total++;
            if ({m_valid, m_id, m_data} !== {1'b1, 2'd0, res_tab[i]}) begin
                bad++; $display("FAIL op_result cfg=%h got=%h want=%h", op_tab[i], {m_valid, m_id, m_data}, {1'b1, 2'd0, res_tab[i]});
            end
        end
    endtask

    task automatic test_round_robin();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_cfg[i] = 4'h3; s_data0[i] = 8'(8'h10 + i); s_data1[i] = 8'h55;
        end
        s_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            #1;
            total++;
            if (s_ready !== 4'(1 << (k % 4))) begin
                bad++; $display("FAIL rr_grant[%0d] got=%b want=%b", k, s_ready, 4'(1 << (k % 4)));
            end
            if (k >= 2) begin
                total++;
                if ({m_valid, m_id, m_data} !== {1'b1, 2'((k - 2) % 4), 8'(8'h10 + (k - 2) % 4)}) begin
                    bad++; $display("FAIL rr_result[%0d] got=%h want=%h", k, {m_valid, m_id, m_data},
                                    {1'b1, 2'((k - 2) % 4), 8'(8'h10 + (k - 2) % 4)});
                end
            end
            @(negedge clk);
        end
        s_valid = '0;
        #1;
        total++;
        if ({m_valid, m_id, m_data} !== {1'b1, 2'd2, 8'h12}) begin
            bad++; $display("FAIL rr_tail0 got=%h want=%h", {m_valid, m_id, m_data}, {1'b1, 2'd2, 8'h12});
        end
        @(negedge clk); #1;
        total++;
        if ({m_valid, m_id, m_data} !== {1'b1, 2'd3, 8'h13}) begin
            bad++; $display("FAIL rr_tail1 got=%h want=%h", {m_valid, m_id, m_data}, {1'b1, 2'd3, 8'h13});
        end
        @(negedge clk); #1;
        total++;
        if (m_valid !== 1'b0) begin
            bad++; $display("FAIL rr_empty got=%b want=0", m_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] exp_head [4];
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) s_data0[i] = 8'(8'h20 + i);
        s_valid = 4'b1111;
        for (int k = 0; k < 7; k++) begin
            #1;
            total++;
            if (s_ready !== ((k < 4) ? 4'(1 << k) : 4'b0000)) begin
                bad++; $display("FAIL bp_accept[%0d] got=%b want=%b", k, s_ready, (k < 4) ? 4'(1 << k) : 4'b0000);
            end
            if (k >= 4) begin
                total++;
                if ({m_valid, m_id, m_data} !== {1'b1, 2'd0, 8'h20}) begin
                    bad++; $display("FAIL bp_hold[%0d] got=%h want=%h", k, {m_valid, m_id, m_data}, {1'b1, 2'd0, 8'h20});
                end
            end
            @(negedge clk);
        end
        m_ready = 1'b1;
        exp_head = '{{1'b1, 2'd0, 8'h20}, {1'b1, 2'd1, 8'h21}, {1'b1, 2'd2, 8'h22}, {1'b1, 2'd3, 8'h23}};
        for (int d = 0; d < 4; d++) begin
            if (d == 2) s_valid = '0;
            #1;
            total++;
            if ({m_valid, m_id, m_data} !== exp_head[d]) begin
                bad++; $display("FAIL bp_drain[%0d] got=%h want=%h", d, {m_valid, m_id, m_data}, exp_head[d]);
            end
            if (d == 1) begin
                total++;
                if (s_ready !== 4'b0001) begin
                    bad++; $display("FAIL bp_resume got=%b want=0001", s_ready);
                end
            end
            @(negedge clk);
        end
        #1;
        total++;
        if ({m_valid, m_id, m_data} !== {1'b1, 2'd0, 8'h20}) begin
            bad++; $display("FAIL bp_new got=%h want=%h", {m_valid, m_id, m_data}, {1'b1, 2'd0, 8'h20});
        end
        @(negedge clk); #1;
        total++;
        if (m_valid !== 1'b0) begin
            bad++; $display("FAIL bp_empty got=%b want=0", m_valid);
        end
    endtask

    task automatic test_cke();
        logic [10:0] exp_out [3];
        for (int i = 0; i < 4; i++) s_data0[i] = 8'(8'h40 + i);
        s_valid = 4'b1111;
        #1;
        total++;
        if (s_ready !== 4'b0010) begin
            bad++; $display("FAIL cke_pre0 got=%b want=0010", s_ready);
        end
        @(negedge clk); #1;
        total++;
        if (s_ready !== 4'b0100) begin
            bad++; $display("FAIL cke_pre1 got=%b want=0100", s_ready);
        end
        @(negedge clk);
        cke = 1'b0;
        #1;
        total++;
        if ({s_ready, m_valid, m_id, m_data} !== {4'b0000, 1'b1, 2'd1, 8'h41}) begin
            bad++; $display("FAIL cke_pop got=%h want=%h", {s_ready, m_valid, m_id, m_data}, {4'b0000, 1'b1, 2'd1, 8'h41});
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            total++;
            if ({s_ready, m_valid} !== 5'b0) begin
                bad++; $display("FAIL cke_frozen[%0d] got=%b want=00000", k, {s_ready, m_valid});
            end
        end
        @(negedge clk);
        cke = 1'b1;
        #1;
        total++;
        if ({s_ready, m_valid} !== 5'b10000) begin
            bad++; $display("FAIL cke_return got=%b want=10000", {s_ready, m_valid});
        end
        @(negedge clk); #1;
        total++;
        if ({s_ready, m_valid, m_id, m_data} !== {4'b0001, 1'b1, 2'd2, 8'h42}) begin
            bad++; $display("FAIL cke_inflight got=%h want=%h", {s_ready, m_valid, m_id, m_data}, {4'b0001, 1'b1, 2'd2, 8'h42});
        end
        exp_out = '{{1'b1, 2'd3, 8'h43}, {1'b1, 2'd0, 8'h40}, 11'h0};
        for (int d = 0; d < 3; d++) begin
            @(negedge clk);
            s_valid = '0;
            #1;
            total++;
            if ({m_valid, m_id, m_data} !== exp_out[d]) begin
                bad++; $display("FAIL cke_tail[%0d] got=%h want=%h", d, {m_valid, m_id, m_data}, exp_out[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) s_data0[i] = 8'(8'h60 + i);
        s_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (s_ready !== 4'(2 << k)) begin
                bad++; $display("FAIL rst_fill[%0d] got=%b want=%b", k, s_ready, 4'(2 << k));
            end
            @(negedge clk);
        end
        reset = 1'b0; s_valid = '0;
        #1;
        total++;
        if ({m_valid, m_id, m_data} !== {1'b1, 2'd1, 8'h61}) begin
            bad++; $display("FAIL rst_queued got=%h want=%h", {m_valid, m_id, m_data}, {1'b1, 2'd1, 8'h61});
        end
        @(negedge clk);
        reset = 1'b1; m_ready = 1'b1;
        #1;
        total++;
        if ({m_valid, m_id, m_data} !== 11'h0) begin
            bad++; $display("FAIL rst_cleared got=%h want=000", {m_valid, m_id, m_data});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            total++;
            if (m_valid !== 1'b0) begin
                bad++; $display("FAIL rst_ghost[%0d] got=%b want=0", k, m_valid);
            end
        end
        s_valid = 4'b1111;
        #1;
        total++;
        if (s_ready !== 4'b0001) begin
            bad++; $display("FAIL rst_first_grant got=%b want=0001", s_ready);
        end
        @(negedge clk);
        s_valid = '0;
        @(negedge clk); #1;
        total++;
        if ({m_valid, m_id, m_data} !== {1'b1, 2'd0, 8'h60}) begin
            bad++; $display("FAIL rst_post_result got=%h want=%h", {m_valid, m_id, m_data}, {1'b1, 2'd0, 8'h60});
        end
        @(negedge clk); #1;
        total++;
        if (m_valid !== 1'b0) begin
            bad++; $display("FAIL rst_post_empty got=%b want=0", m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_op_sweep();
        test_round_robin();
        test_backpressure();
        test_cke();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
